// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sequencer that sweeps every input combination of a small
// combinational function, samples its output into a truth-table register and
// compares the captured table against a latched expected minterm mask.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst_n          - synchronous active-low reset
//   start          - begin a sweep; honoured only in IDLE
//   expected       - expected output per vector (bit i = f(i)), latched on start
//   dut_in         - drive to the function inputs (MSB = input a)
//   dut_out        - function output f
//   busy           - sweep in progress (start edge through last SAMPLE)
//   done           - one-cycle pulse at the end of a sweep
//   pass           - no mismatches in the last sweep; held until next start
//   truth_table    - captured outputs, bit i = sampled f for vector i
//   mismatch_count - number of vectors whose sample differed from expected
//   fail_valid     - at least one mismatch seen this sweep
//   first_fail_idx - index of first mismatching vector (valid with fail_valid)
//
// Optional build macro:
//   TT_STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep.

module tt_sweep_ctrl #(
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [(1<<NUM_IN)-1:0]   expected,
  output logic [NUM_IN-1:0]        dut_in,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [(1<<NUM_IN)-1:0]   truth_table,
  output logic [NUM_IN:0]          mismatch_count,
  output logic                     fail_valid,
  output logic [NUM_IN-1:0]        first_fail_idx
);

  localparam int unsigned NV    = 1 << NUM_IN;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned MC_W  = NUM_IN + 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_IN-1:0] IDX_LAST    = NUM_IN'(NV - 1);
  localparam logic [NUM_IN-1:0] IDX_ONE     = NUM_IN'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [MC_W-1:0]   MC_ONE      = MC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IN-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NV-1:0]       exp_q, exp_d;
  logic [NUM_IN-1:0]   dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [NV-1:0]       tt_q, tt_d;
  logic [MC_W-1:0]     mc_q, mc_d;
  logic                fv_q, fv_d;
  logic [NUM_IN-1:0]   ff_q, ff_d;
  logic                miss_c;
  logic                end_c;

  // Sample of the current vector disagrees with the latched expectation.
  assign miss_c = (dut_out != exp_q[idx_q]);

  // Condition that terminates the sweep at a SAMPLE cycle.
`ifdef TT_STOP_ON_FAIL_EN
  assign end_c = miss_c || (idx_q == IDX_LAST);
`else
  assign end_c = (idx_q == IDX_LAST);
`endif

  // Next-state and output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    tt_d     = tt_q;
    mc_d     = mc_q;
    fv_d     = fv_q;
    ff_d     = ff_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d    = expected;
          idx_d    = '0;
          dut_in_d = '0;
          cnt_d    = '0;
          tt_d     = '0;
          mc_d     = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
          pass_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        tt_d[idx_q] = dut_out;
        if (miss_c) begin
          mc_d = mc_q + MC_ONE;
          if (!fv_q) begin
            ff_d = idx_q;
            fv_d = 1'b1;
          end
        end
        if (end_c) begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + IDX_ONE;
          dut_in_d = idx_q + IDX_ONE;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (mc_q == '0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tt_q     <= '0;
      mc_q     <= '0;
      fv_q     <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      tt_q     <= tt_d;
      mc_q     <= mc_d;
      fv_q     <= fv_d;
      ff_q     <= ff_d;
    end
  end

  assign dut_in         = dut_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign truth_table    = tt_q;
  assign mismatch_count = mc_q;
  assign fail_valid     = fv_q;
  assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: directed scenarios plus randomized
// function/expected pairs, checked against a truth-table reference model.
module tb_tt_sweep_ctrl;

  localparam int NUM_IN = 4;
  localparam int NV     = 16;
  localparam int SC     = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [15:0]   expected;
  logic [3:0]    dut_in;
  logic          dut_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   truth_table;
  logic [4:0]    mismatch_count;
  logic          fail_valid;
  logic [3:0]    first_fail_idx;

  logic [15:0]   fn_tt;
  int            n_total;
  int            n_bad;

  // Model model outputs
  logic [15:0]   m_tt;
  int            m_mc;
  int            m_first;
  bit            m_fv;
  int            m_lat;
  int            m_last;

  tt_sweep_ctrl #(.NUM_IN(NUM_IN), .SETTLE_CYCLES(SC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .expected       (expected),
    .dut_in         (dut_in),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .truth_table    (truth_table),
    .mismatch_count (mismatch_count),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx)
  );

  // Function under test: a lookup of the currently selected table.
  assign dut_out = fn_tt[dut_in];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected sweep results from the function table and the expected mask.
  task automatic model(input logic [15:0] exp_mask);
    logic [15:0] miss;
    miss    = fn_tt ^ exp_mask;
    m_tt    = fn_tt;
    m_mc    = $countones(miss);
    m_fv    = (miss != 16'h0);
    m_first = 0;
    for (int i = NV - 1; i >= 0; i--) if (miss[i]) m_first = i;
    m_lat   = NV * (SC + 1) + 1;
    m_last  = NV - 1;
`ifdef TT_STOP_ON_FAIL_EN
    if (m_fv) begin
      m_mc   = 1;
      m_tt   = fn_tt & ((16'(1) << (m_first + 1)) - 16'(1));
      m_lat  = (m_first + 1) * (SC + 1) + 1;
      m_last = m_first;
    end
`endif
  endtask

  // One sweep; optional mid-sweep start pokes / expected changes, or a reset.
  task automatic run_sweep(input string tag, input logic [15:0] exp_mask,
                           input bit poke, input int rst_at);
    int  lat;
    int  ndone;
    model(exp_mask);
    @(negedge clk);
    expected = exp_mask;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_pass_clr"}, pass, 0);
    chk({tag, "_mc_clr"}, mismatch_count, 0);
    chk({tag, "_din0"}, dut_in, 0);
    lat = 0;
    for (int n = 1; n <= m_lat + 5 && lat == 0; n++) begin
      if (poke && (n == 5 || n == 30)) start = 1'b1;
      if (poke && (n == 6 || n == 31)) start = 1'b0;
      if (poke && n == 10) expected = 16'($urandom);
      if (n == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
      if (n == rst_at) begin
        rst_n = 1'b1;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_din"}, dut_in, 0);
        chk({tag, "_rst_tt"}, truth_table, 0);
        chk({tag, "_rst_mc"}, mismatch_count, 0);
        chk({tag, "_rst_fail"}, {fail_valid, first_fail_idx, pass}, 0);
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
          @(posedge clk); #1;
          if (done) ndone++;
        end
        chk({tag, "_rst_no_done"}, ndone, 0);
        return;
      end
      if (n < m_lat - 1) chk({tag, "_busy_mid"}, busy, 1);
      if (done) lat = n;
    end
    chk({tag, "_latency"}, lat, m_lat);
    chk({tag, "_tt"}, truth_table, m_tt);
    chk({tag, "_mc"}, mismatch_count, m_mc);
    chk({tag, "_fv"}, fail_valid, m_fv);
    if (m_fv) chk({tag, "_first"}, first_fail_idx, m_first);
    chk({tag, "_pass"}, pass, (m_mc == 0));
    chk({tag, "_busy_end"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_pass_hold"}, pass, (m_mc == 0));
    chk({tag, "_din_last"}, dut_in, m_last);
  endtask

  initial begin
    int dn[$];
    int ndr;
    logic [15:0] flips;
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    expected = 16'h0;
    fn_tt    = 16'hF000;  // f = a & b
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, pass, fail_valid, dut_in, truth_table,
                        mismatch_count, first_fail_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_sweep("s1_match", 16'hF000, 1'b0, 0);
    run_sweep("s2_one_miss", 16'hF001, 1'b0, 0);
    run_sweep("s3_all_miss", 16'h0FFF, 1'b0, 0);
    run_sweep("s4_poke", 16'hF000, 1'b1, 0);
    run_sweep("s5_reset", 16'hF000, 1'b0, 20);
    run_sweep("s5_after", 16'hF000, 1'b0, 0);

    // Start held high: back-to-back sweeps with a single IDLE gap.
    @(negedge clk);
    expected = 16'hF000;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dn.push_back(n);
        chk("s6_pass", pass, 1);
      end
      if (n == 49) chk("s6_idle_gap", busy, 0);
      if (n == 50) chk("s6_restart", busy, 1);
    end
    start = 1'b0;
    chk("s6_ndone", dn.size(), 2);
    chk("s6_done1", (dn.size() > 0) ? dn[0] : 0, 49);
    chk("s6_done2", (dn.size() > 1) ? dn[1] : 0, 99);
    ndr = 0;
    for (int k = 0; k < 80 && ndr == 0; k++) begin
      @(posedge clk); #1;
      if (done) ndr = 1;
    end
    chk("s6_drain", ndr, 1);
    @(posedge clk); #1;

    // Randomized functions with a few flipped expectation bits.
    for (int it = 0; it < 8; it++) begin
      fn_tt = 16'($urandom);
      flips = 16'h0;
      repeat ($urandom_range(0, 3)) flips |= 16'(1) << $urandom_range(0, 15);
      run_sweep("rand", fn_tt ^ flips, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
